pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Pipeline control block for the 5-stage RV32 core that consumes hazard indications and turns them into per-stage register enables, bubble/flush strobes and a registered PC redirect. It sits beside the data-hazard/forwarding unit: that unit detects load-use and asserts a stall request, and this block stalls the front end and inserts the bubble. It also arbitrates EX-stage taken branches/jumps and multi-cycle data-memory accesses, which the forwarding logic does not handle.

## Interface
- `CNT_W`, 32: width of the performance counters.

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `lu_hazard`  in  1  load-use stall request from the data-hazard unit; ID instruction needs the result of a load in EX.
- `br_taken`  in  1  EX stage resolved a taken branch, `jal` or `jalr`.
- `br_target`  in  32  redirect address, valid with `br_taken`.
- `dmem_req`  in  1  MEM stage has a load or store outstanding.
- `dmem_ack`  in  1  data memory completes the MEM-stage access this cycle.
- `if_en`, `id_en`, `ex_en`, `mem_en`  out  1 each  load enables for PC, IF/ID, ID/EX and EX/MEM registers.
- `id_flush`, `ex_flush`, `wb_flush`  out  1 each  load a NOP bubble into IF/ID, ID/EX and MEM/WB.
- `redirect_valid`  out  1  registered; PC loads `redirect_pc` this cycle.
- `redirect_pc`  out  32  registered redirect target.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters.

## Operation
- FSM states: `RUN`, `REDIRECT`, `MEM_WAIT`. `MEM_WAIT` also saves a return state, either `RUN` or `REDIRECT`.
- Priority order: memory wait, then branch, then load-use.
- `MEM_WAIT` is entered from `RUN` or `REDIRECT` when `dmem_req && !dmem_ack`.
  - While waiting: all four enables are 0, `wb_flush` is 1, and the other flushes are 0.
  - `redirect_valid` and `redirect_pc` hold their values.
  - On `dmem_ack`: enables return to their normal values in the same cycle, and the next state is the saved return state.
- `RUN` with `br_taken` (and no memory wait):
  - `id_flush` and `ex_flush` are 1 in that cycle.
  - `redirect_pc` is set to `br_target`, `redirect_valid` is set to 1, and the next state is `REDIRECT`.
- `REDIRECT`:
  - `redirect_valid` is 1 and `id_flush` is 1; this kills the wrong-path fetch.
  - `br_taken` and `lu_hazard` are ignored, since the pipeline holds bubbles.
  - Next state is `RUN`, with `redirect_valid` cleared.
- `RUN` with `lu_hazard`, no branch and no memory wait:
  - `if_en` and `id_en` are 0, `ex_flush` is 1, and `ex_en` and `mem_en` are 1.
  - The `lu_block` flop is set. While `lu_block` is 1 in the next cycle, `lu_hazard` is ignored, which prevents a double stall. The flop clears after one cycle.
- Idle `RUN`: all enables are 1 and all flushes are 0.
- Outputs during `rst_n`=0: enables 0, flushes 0, `redirect_valid` 0, `redirect_pc` 0, state `RUN`, `lu_block` 0, counters 0.

## Timing
- Enables and flushes are combinational from the state and the inputs, with zero-cycle latency.
- `redirect_valid` and `redirect_pc` are registered and appear one cycle after `br_taken` is sampled.
- Taken branch penalty is 2 bubbles: one in the detection cycle and one in `REDIRECT`.
- Load-use penalty is exactly 1 cycle.
- A memory wait lasts as many cycles as `dmem_ack` stays low after `dmem_req`. An ack in the same cycle as the request costs 0 stall cycles.
- Simultaneous `br_taken` and `lu_hazard`: the branch wins and the load-use request is dropped, because the ID instruction is wrong-path.
- Simultaneous `br_taken` and a memory wait: the branch is not acted on. `br_taken` stays asserted because EX is frozen, and it is taken on the exit cycle.
- Reset asserted mid-stall or mid-redirect returns all outputs to reset values immediately, asynchronously.

## Configuration
- `PIPE_STALL_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `if_en`=0 while out of reset.
  - `flush_cnt` increments on each `RUN`→`REDIRECT` transition.
  - Both counters saturate at 2^CNT_W−1.
- Not defined: both ports are driven constant 0 and no counter flops are built.

## Test plan
- Load-use: `lu_hazard`=1 for 2 cycles in `RUN` → cycle 1 `if_en`=`id_en`=0 and `ex_flush`=1; cycle 2 all enables 1 (`lu_block`); `stall_cnt`=1.
- Branch: `br_taken`=1 with `br_target`=0x0000_0100 → same cycle `id_flush`=`ex_flush`=1; next cycle `redirect_valid`=1, `redirect_pc`=0x100, `id_flush`=1; then `RUN`; `flush_cnt`=1.
- Memory wait: `dmem_req`=1 with `dmem_ack` low for 3 cycles → 3 cycles of all enables 0 and `wb_flush`=1; enables go high in the ack cycle; `stall_cnt`=3.
- Branch plus memory wait: `br_taken` and `dmem_req` rise together with ack after 2 cycles → no redirect during the wait; `redirect_valid`=1 one cycle after the ack cycle.
- Mid-operation reset: `rst_n` dropped during `REDIRECT` → `redirect_valid`=0 and enables 0 without waiting for a clock edge; after release, state is `RUN` and counters read 0.
- Counter saturation (macro on, `CNT_W`=4): 20 load-use stalls → `stall_cnt`=15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush/redirect control for the 5-stage RV32 pipeline.
// Optional perf counters are built only when PIPE_STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lu_hazard,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             wb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, REDIRECT, MEM_WAIT} state_t;

  state_t      state_q, state_d, ret_q, ret_d, eff;
  logic        lu_block_q, lu_set, br_go, mem_stall;
  logic        rv_d;
  logic [31:0] pc_d;
  logic        if_en_c, id_en_c, ex_en_c, mem_en_c;
  logic        id_flush_c, ex_flush_c, wb_flush_c;

  always_comb begin
    // MEM_WAIT behaves as its saved return state once the ack arrives
    eff        = (state_q == MEM_WAIT) ? ret_q : state_q;
    mem_stall  = !dmem_ack && (dmem_req || state_q == MEM_WAIT);
    if_en_c    = 1'b1;
    id_en_c    = 1'b1;
    ex_en_c    = 1'b1;
    mem_en_c   = 1'b1;
    id_flush_c = 1'b0;
    ex_flush_c = 1'b0;
    wb_flush_c = 1'b0;
    state_d    = eff;
    ret_d      = ret_q;
    lu_set     = 1'b0;
    br_go      = 1'b0;
    rv_d       = redirect_valid;
    pc_d       = redirect_pc;
    if (mem_stall) begin
      if_en_c    = 1'b0;
      id_en_c    = 1'b0;
      ex_en_c    = 1'b0;
      mem_en_c   = 1'b0;
      wb_flush_c = 1'b1;
      state_d    = MEM_WAIT;
      ret_d      = eff;
    end else if (eff == REDIRECT) begin
      id_flush_c = 1'b1;
      state_d    = RUN;
      rv_d       = 1'b0;
    end else if (br_taken) begin
      id_flush_c = 1'b1;
      ex_flush_c = 1'b1;
      rv_d       = 1'b1;
      pc_d       = br_target;
      state_d    = REDIRECT;
      br_go      = 1'b1;
    end else if (lu_hazard && !lu_block_q) begin
      if_en_c    = 1'b0;
      id_en_c    = 1'b0;
      ex_flush_c = 1'b1;
      lu_set     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      ret_q          <= RUN;
      lu_block_q     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      lu_block_q     <= lu_set;
      redirect_valid <= rv_d;
      redirect_pc    <= pc_d;
    end
  end

  // Combinational controls are forced low while reset is held
  assign if_en    = rst_n & if_en_c;
  assign id_en    = rst_n & id_en_c;
  assign ex_en    = rst_n & ex_en_c;
  assign mem_en   = rst_n & mem_en_c;
  assign id_flush = rst_n & id_flush_c;
  assign ex_flush = rst_n & ex_flush_c;
  assign wb_flush = rst_n & wb_flush_c;

`ifdef PIPE_STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!if_en_c && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (br_go && flush_q != '1)    flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_br_go;
  assign unused_br_go = br_go;
  assign stall_cnt    = '0;
  assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; counter expectations follow PIPE_STALL_PERF_CNT_EN.
module tb_pipe_stall_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lu_hazard = 1'b0, br_taken = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic [31:0]      br_target = '0;
  logic             if_en, id_en, ex_en, mem_en, id_flush, ex_flush, wb_flush, redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0]       ctl;
  int               total = 0, bad = 0;

  pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .lu_hazard(lu_hazard), .br_taken(br_taken),
    .br_target(br_target), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en),
    .id_flush(id_flush), .ex_flush(ex_flush), .wb_flush(wb_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {if_en,id_en,ex_en,mem_en,id_flush,ex_flush,wb_flush,redirect_valid}
  assign ctl = {if_en, id_en, ex_en, mem_en, id_flush, ex_flush, wb_flush, redirect_valid};

`ifdef PIPE_STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] cexp(input int v);
    return PERF ? CNT_W'(v) : '0;
  endfunction

  // apply one cycle of inputs at the falling edge; outputs settle 1ns later
  task automatic cyc(input logic lu, input logic br, input logic [31:0] tgt,
                     input logic req, input logic ack);
    @(negedge clk);
    lu_hazard = lu; br_taken = br; br_target = tgt; dmem_req = req; dmem_ack = ack;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lu_hazard = 0; br_taken = 0; br_target = '0; dmem_req = 0; dmem_ack = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'h00); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", redirect_pc); end
    total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    do_reset();
    cyc(0, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL idle_ctl got=%b exp=11110000", ctl); end
  endtask

  task automatic test_load_use();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    total++; if (ctl !== 8'b0011_0100) begin bad++; $display("FAIL lu_c1 got=%b exp=00110100", ctl); end
    cyc(1, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL lu_block got=%b exp=11110000", ctl); end
    cyc(1, 0, 0, 0, 0);
    total++; if (ctl !== 8'b0011_0100) begin bad++; $display("FAIL lu_reissue got=%b exp=00110100", ctl); end
    cyc(0, 0, 0, 0, 0);
    total++; if (stall_cnt !== cexp(2)) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, cexp(2)); end
  endtask

  task automatic test_branch();
    do_reset();
    cyc(0, 1, 32'h0000_0100, 0, 0);
    total++; if (ctl !== 8'b1111_1100) begin bad++; $display("FAIL br_detect got=%b exp=11111100", ctl); end
    cyc(1, 1, 32'h0000_0200, 0, 0);  // ignored while in REDIRECT
    total++; if (ctl !== 8'b1111_1001) begin bad++; $display("FAIL br_redirect got=%b exp=11111001", ctl); end
    total++; if (redirect_pc !== 32'h100) begin bad++; $display("FAIL br_pc got=%h exp=00000100", redirect_pc); end
    cyc(0, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL br_back_run got=%b exp=11110000", ctl); end
    total++; if (flush_cnt !== cexp(1) || stall_cnt !== cexp(0)) begin
      bad++; $display("FAIL br_cnt got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, cexp(1), cexp(0)); end
  endtask

  task automatic test_br_lu();
    do_reset();
    cyc(1, 1, 32'h0000_0ABC, 0, 0);
    total++; if (ctl !== 8'b1111_1100) begin bad++; $display("FAIL brlu_detect got=%b exp=11111100", ctl); end
    cyc(1, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_1001 || redirect_pc !== 32'hABC) begin
      bad++; $display("FAIL brlu_redirect got=%b/%h exp=11111001/00000abc", ctl, redirect_pc); end
    cyc(0, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_0000 || stall_cnt !== cexp(0)) begin
      bad++; $display("FAIL brlu_run got=%b/%0d exp=11110000/%0d", ctl, stall_cnt, cexp(0)); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      total++; if (ctl !== 8'b0000_0010) begin bad++; $display("FAIL mem_wait%0d got=%b exp=00000010", i, ctl); end
    end
    cyc(0, 0, 0, 1, 1);
    total++; if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL mem_ack got=%b exp=11110000", ctl); end
    cyc(0, 0, 0, 1, 1);  // same-cycle ack costs nothing
    total++; if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL mem_fast got=%b exp=11110000", ctl); end
    cyc(0, 0, 0, 0, 0);
    total++; if (stall_cnt !== cexp(3)) begin bad++; $display("FAIL mem_stall_cnt got=%0d exp=%0d", stall_cnt, cexp(3)); end
  endtask

  task automatic test_br_mem();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 32'h0000_0100, 1, 0);
      total++; if (ctl !== 8'b0000_0010) begin bad++; $display("FAIL brmem_wait%0d got=%b exp=00000010", i, ctl); end
    end
    cyc(0, 1, 32'h0000_0100, 1, 1);
    total++; if (ctl !== 8'b1111_1100) begin bad++; $display("FAIL brmem_exit got=%b exp=11111100", ctl); end
    cyc(0, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_1001 || redirect_pc !== 32'h100) begin
      bad++; $display("FAIL brmem_redirect got=%b/%h exp=11111001/00000100", ctl, redirect_pc); end
    cyc(0, 0, 0, 0, 0);
    total++; if (stall_cnt !== cexp(2) || flush_cnt !== cexp(1)) begin
      bad++; $display("FAIL brmem_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, cexp(2), cexp(1)); end
  endtask

  task automatic test_redirect_mem();
    do_reset();
    cyc(0, 1, 32'h0000_0040, 0, 0);
    cyc(0, 0, 0, 1, 0);
    total++; if (ctl !== 8'b0000_0011) begin bad++; $display("FAIL rdmem_enter got=%b exp=00000011", ctl); end
    cyc(0, 0, 0, 1, 0);
    total++; if (ctl !== 8'b0000_0011 || redirect_pc !== 32'h40) begin
      bad++; $display("FAIL rdmem_hold got=%b/%h exp=00000011/00000040", ctl, redirect_pc); end
    cyc(0, 0, 0, 1, 1);
    total++; if (ctl !== 8'b1111_1001) begin bad++; $display("FAIL rdmem_exit got=%b exp=11111001", ctl); end
    cyc(0, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_0000) begin bad++; $display("FAIL rdmem_run got=%b exp=11110000", ctl); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1, 1, 32'h0000_0100, 0, 0);
    cyc(0, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_1001) begin bad++; $display("FAIL mr_pre got=%b exp=11111001", ctl); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (ctl !== 8'h00 || redirect_pc !== 32'h0) begin
      bad++; $display("FAIL mr_async got=%b/%h exp=00000000/00000000", ctl, redirect_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    total++; if (ctl !== 8'b1111_0000 || stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++; $display("FAIL mr_after got=%b/%0d/%0d exp=11110000/0/0", ctl, stall_cnt, flush_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    total++; if (stall_cnt !== cexp(15)) begin bad++; $display("FAIL sat_stall got=%0d exp=%0d", stall_cnt, cexp(15)); end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 32'h8, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);
    total++; if (flush_cnt !== cexp(15)) begin bad++; $display("FAIL sat_flush got=%0d exp=%0d", flush_cnt, cexp(15)); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_br_lu();
    test_mem_wait();
    test_br_mem();
    test_redirect_mem();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
